// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared FIFO entry type, write-FSM states and default SDRAM bank map
package rom_loader_pkg;
  typedef struct packed {
    logic [8:0]  bank;
    logic [13:0] offs;
    logic [7:0]  data;
  } loader_entry_t;
  typedef enum logic {IDLE, WRITE} state_t;
  localparam logic [8:0] BANK0_DEF = 9'h000;
  localparam logic [8:0] BANK1_DEF = 9'h100;
  localparam logic [8:0] BANK2_DEF = 9'h107;
endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: ioctl download port in, zsdram boot-write port out
interface rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [7:0]  boot_dout;
  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
                  input  boot_wr, boot_a, boot_dout);
  modport slave  (input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
                  output boot_wr, boot_a, boot_dout);
endinterface

// File: rtl/rom_loader_fifo.sv
// loader_fifo: show-ahead synchronous FIFO of loader entries; push on full is accepted only alongside a pop
module loader_fifo import rom_loader_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          push,
  input  logic          pop,
  input  loader_entry_t din,
  output loader_entry_t dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  loader_entry_t mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk_sys)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: maps ROM-image download pages onto SDRAM banks, one write per clkref slot,
// holding the core in reset until the image is fully committed
module rom_loader import rom_loader_pkg::*; #(
  parameter logic [7:0] ROM_INDEX  = 8'd0,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [8:0] BANK0      = BANK0_DEF,
  parameter logic [8:0] BANK1      = BANK1_DEF,
  parameter logic [8:0] BANK2      = BANK2_DEF
) (
  input  logic         clk_sys,
  input  logic         RESET_n,
  input  logic         clkref,
  rom_loader_if.slave  bus,
  output logic         hold_reset,
  output logic         load_done,
  output logic         err_overflow
);
  state_t        state, state_nx;
  loader_entry_t din, head;
  logic [10:0]   page;
  logic [22:0]   boot_a;
  logic [7:0]    boot_dout;
  logic          full, empty, rom_dl, rom_dl_q, hold_q, got_byte, accept, pop;
  assign rom_dl     = bus.ioctl_download && bus.ioctl_index == ROM_INDEX;
  assign page       = bus.ioctl_addr[24:14];
  assign accept     = bus.ioctl_wr && rom_dl && page < 11'd3;
  assign pop        = clkref && !empty;
  assign din        = '{bank: page == 11'd0 ? BANK0 : page == 11'd1 ? BANK1 : BANK2,
                        offs: bus.ioctl_addr[13:0], data: bus.ioctl_dout};
  assign hold_reset = rom_dl || !empty || state == WRITE;
  assign load_done  = hold_q && !hold_reset && got_byte;
  assign bus.boot_wr   = state == WRITE;
  assign bus.boot_a    = boot_a;
  assign bus.boot_dout = boot_dout;
  loader_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .push(accept), .pop(pop),
    .din(din), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk_sys)
    state <= !RESET_n ? IDLE : state_nx;
  // every slot either starts the next queued byte or ends the burst
  always_comb state_nx = clkref ? (empty ? IDLE : WRITE) : state;
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      boot_a       <= '0;
      boot_dout    <= '0;
      err_overflow <= 1'b0;
      rom_dl_q     <= 1'b0;
      hold_q       <= 1'b0;
      got_byte     <= 1'b0;
    end else begin
      if (pop) {boot_a, boot_dout} <= {head.bank, head.offs, head.data};
      err_overflow <= (err_overflow && !(rom_dl && !rom_dl_q)) || (accept && full && !pop);
      rom_dl_q     <= rom_dl;
      hold_q       <= hold_reset;
      got_byte     <= accept || (got_byte && !load_done);
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed stimulus with a scoreboard of expected SDRAM writes
module tb_rom_loader;
  logic clk_sys = 1'b0, RESET_n = 1'b0, clkref = 1'b0, cref_en = 1'b1;
  logic hold_reset, load_done, err_overflow;
  logic [3:0] cnt = 4'd0;
  logic [30:0] exp_q [$];
  int checks = 0, failures = 0;
  int slots = 0, wr_cycles = 0, falls = 0, dones = 0;
  int s0, w0, f0, d0;
  rom_loader_if bus ();
  rom_loader dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .clkref(clkref), .bus(bus),
    .hold_reset(hold_reset), .load_done(load_done), .err_overflow(err_overflow)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((hold_reset || bus.boot_wr) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n == 2000) check("drain_timeout", hold_reset, 0);
    repeat (2) @(negedge clk_sys);
  endtask
  function automatic void snap();
    s0 = slots; w0 = wr_cycles; f0 = falls; d0 = dones;
  endfunction
  initial forever begin
    @(negedge clk_sys);
    cnt = cnt + 4'd1;
    clkref = cref_en && cnt == 4'd0;
  end
  logic wr_prev = 1'b0;
  initial forever begin
    logic cr;
    logic [30:0] e;
    @(posedge clk_sys);
    cr = clkref;
    #1;
    if (bus.boot_wr) wr_cycles++;
    if (wr_prev && !bus.boot_wr) falls++;
    wr_prev = bus.boot_wr;
    if (load_done) dones++;
    if (bus.boot_wr && cr) begin
      slots++;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("boot_a", bus.boot_a, e[30:8]);
        check("boot_dout", bus.boot_dout, e[7:0]);
      end
    end
  end
  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    repeat (4) @(negedge clk_sys);
    #1;
    check("rst_boot_wr", bus.boot_wr, 0);
    check("rst_boot_a", bus.boot_a, 0);
    check("rst_boot_dout", bus.boot_dout, 0);
    check("rst_hold", hold_reset, 0);
    check("rst_done", load_done, 0);
    check("rst_err", err_overflow, 0);
    @(negedge clk_sys);
    RESET_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    // single byte
    snap();
    bus.ioctl_download = 1'b1;
    #1 check("hold_comb", hold_reset, 1);
    exp_q.push_back({23'h000004, 8'hA5});
    wr_byte(25'h0004, 8'hA5);
    bus.ioctl_download = 1'b0;
    wait_idle();
    check("single_slots", slots - s0, 1);
    check("single_len", wr_cycles - w0, 16);
    check("single_done", dones - d0, 1);
    check("single_hold", hold_reset, 0);
    // bank map, page 3 discarded
    snap();
    bus.ioctl_download = 1'b1;
    exp_q.push_back({23'h400000, 8'h11});
    exp_q.push_back({23'h41C123, 8'h22});
    wr_byte(25'h4000, 8'h11);
    wr_byte(25'h8123, 8'h22);
    wr_byte(25'hC000, 8'h33);
    bus.ioctl_download = 1'b0;
    wait_idle();
    check("map_slots", slots - s0, 2);
    check("map_err", err_overflow, 0);
    check("map_done", dones - d0, 1);
    // overflow burst with clkref stalled
    cref_en = 1'b0;
    repeat (3) @(negedge clk_sys);
    snap();
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back({23'h000010 + 23'(i), 8'hC0 + 8'(i)});
      wr_byte(25'h10 + 25'(i), 8'hC0 + 8'(i));
    end
    #1 check("burst_err", err_overflow, 1);
    bus.ioctl_download = 1'b0;
    cref_en = 1'b1;
    wait_idle();
    check("burst_slots", slots - s0, 4);
    check("err_sticky", err_overflow, 1);
    snap();
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    #1 check("err_clear", err_overflow, 0);
    bus.ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("empty_dl_done", dones - d0, 0);
    // paced stream, phase offset from clkref
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_sys);
      #1;
      if (clkref) break;
    end
    repeat (5) @(negedge clk_sys);
    snap();
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({23'h400000 + 23'(i), 8'(i) ^ 8'h5A});
      wr_byte(25'h4000 + 25'(i), 8'(i) ^ 8'h5A);
      repeat (15) @(negedge clk_sys);
    end
    bus.ioctl_download = 1'b0;
    wait_idle();
    check("paced_slots", slots - s0, 64);
    check("paced_len", wr_cycles - w0, 64 * 16);
    check("paced_gaps", falls - f0, 1);
    check("paced_err", err_overflow, 0);
    check("paced_done", dones - d0, 1);
    // reset mid-slot with two entries queued
    snap();
    bus.ioctl_download = 1'b1;
    exp_q.push_back({23'h000020, 8'hE0});
    wr_byte(25'h20, 8'hE0);
    wr_byte(25'h21, 8'hE1);
    wr_byte(25'h22, 8'hE2);
    bus.ioctl_download = 1'b0;
    for (int n = 0; n < 40 && !bus.boot_wr; n++) @(negedge clk_sys);
    check("rst_slot_started", bus.boot_wr, 1);
    RESET_n = 1'b0;
    @(negedge clk_sys);
    #1;
    check("rst_mid_wr", bus.boot_wr, 0);
    check("rst_mid_hold", hold_reset, 0);
    RESET_n = 1'b1;
    repeat (40) @(negedge clk_sys);
    check("rst_mid_slots", slots - s0, 1);
    check("rst_mid_hold_after", hold_reset, 0);
    check("rst_mid_done", dones - d0, 0);
    // foreign index
    snap();
    bus.ioctl_index = 8'd1;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) wr_byte(25'(i), 8'(i));
    #1 check("foreign_hold", hold_reset, 0);
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'd0;
    repeat (40) @(negedge clk_sys);
    check("foreign_slots", slots - s0, 0);
    check("foreign_done", dones - d0, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sits between the mist_io ioctl download port and the zsdram boot-write inputs.
- Filters ROM-image downloads (index 0) and maps 16 KB pages of the image onto SDRAM ROM banks.
- Buffers bytes in a small FIFO and issues one SDRAM write per clkref slot.
- Holds the core in reset until the last byte has been committed, so the CPU never runs from a half-written ROM.

Parameters:
- ROM_INDEX, 0: ioctl_index value that selects a ROM download.
- FIFO_DEPTH, 4: buffered byte entries; must be a power of 2, minimum 2.
- BANK0, 9'h000: SDRAM bank (boot_a[22:14]) for image page 0 (OS ROM).
- BANK1, 9'h100: SDRAM bank for image page 1 (BASIC ROM).
- BANK2, 9'h107: SDRAM bank for image page 2 (AMSDOS ROM).

Ports:
- clk_sys  in  1  system clock; all logic runs on its rising edge.
- RESET_n  in  1  synchronous, active-low reset.
- clkref  in  1  one-cycle SDRAM slot strobe (ce_ref), once per 16 clk_sys.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download type.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  25  byte offset within the image.
- ioctl_dout  in  8  byte data.
- boot_wr  out  1  SDRAM write request.
- boot_a  out  23  SDRAM byte address.
- boot_dout  out  8  SDRAM write data.
- hold_reset  out  1  keep the core in reset.
- load_done  out  1  one-cycle pulse when a ROM load has fully drained.
- err_overflow  out  1  sticky: a byte was lost because the FIFO was full.

Behaviour:
- Reset (RESET_n=0 at a clk_sys edge):
  - FIFO emptied, state IDLE.
  - boot_wr=0, boot_a=0, boot_dout=0, hold_reset=0, load_done=0, err_overflow=0.
  - Reset mid-write abandons the write without completing it.
- Active download (rom_dl): ioctl_download=1 and ioctl_index==ROM_INDEX.
- Accept: ioctl_wr=1 while rom_dl. Page = ioctl_addr[24:14].
  - Page 0, 1, 2 → push {bank, ioctl_addr[13:0], ioctl_dout}.
  - Any other page → byte discarded silently; no error.
- Overflow: an accept while the FIFO is full (and no pop in the same cycle) drops the byte and sets err_overflow.
  - err_overflow clears at the rising edge of rom_dl.
  - Simultaneous push and pop on a full FIFO is legal; the byte is kept.
- Write state machine:
  - IDLE: on clkref with the FIFO non-empty → WRITE.
    - In the same edge, load boot_a and boot_dout from the FIFO head, pop it, and set boot_wr=1.
  - WRITE: boot_wr, boot_a and boot_dout are held stable for the whole slot. On the next clkref:
    - FIFO non-empty → load the next entry and pop; stay in WRITE (back-to-back, one byte per slot).
    - FIFO empty → boot_wr=0; go to IDLE.
  - Latency: a byte pushed at cycle t is on boot_wr at the first clkref after t (FIFO previously empty, state IDLE). Maximum 16 clk_sys cycles.
- hold_reset = rom_dl | FIFO non-empty | (state==WRITE).
  - Goes high combinationally with rom_dl.
  - Drops in the cycle after the final slot ends.
- load_done pulses for one cycle on the falling edge of hold_reset.
  - Only when at least one byte was accepted during that download.
- A download with another index is ignored entirely: no hold_reset, no writes.
- rom_dl deasserting while the FIFO is non-empty: draining continues to completion.
- A new rom_dl starting while draining: the old entries are written first, then the new ones. The FIFO is not flushed.
- Pointer arithmetic: log2(FIFO_DEPTH)-bit read/write pointers, wrapping naturally. Count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package rom_loader_pkg:
  - typedef loader_entry_t {bank[8:0], offs[13:0], data[7:0]}.
  - state enum {IDLE, WRITE}.
  - Default bank constants.
- Sub-module loader_fifo (synchronous FIFO, parameter FIFO_DEPTH, entry type loader_entry_t).
  - Ports: push, pop, full, empty, din, dout (show-ahead).

Test Plan:
- Single byte: ioctl_addr=0x0004, dout=0xA5, clkref every 16 cycles.
  - → one boot_wr slot of 16 cycles, boot_a=0x000004, boot_dout=0xA5.
  - → hold_reset drops afterwards; load_done pulses once.
- Bank map: bytes at 0x4000, 0x8123, 0xC000.
  - → boot_a=0x400000 and 0x41C123 are written.
  - → 0xC000 is never written; err_overflow stays 0.
- Burst: 6 ioctl_wr on consecutive cycles, FIFO_DEPTH=4, no clkref during the burst.
  - → 4 bytes are written in order, err_overflow=1.
  - → err_overflow clears on the next rom_dl rise.
- Paced stream: 64 bytes, one every 16 cycles, phase-offset from clkref.
  - → 64 back-to-back slots, no loss.
  - → boot_wr stays continuously high from the first slot to the last.
- Reset mid-slot: RESET_n=0 during WRITE with 2 entries queued.
  - → next cycle boot_wr=0 and hold_reset=0; the FIFO is empty after reset.
- Foreign index: ioctl_index=1 with 10 writes.
  - → no boot_wr, hold_reset stays 0, no load_done.
